// File: rtl/lieat_ifu_fetch_rspq_pkg.sv
`default_nettype none
// ============================================================================
// Module : lieat_ifu_fetch_rspq_pkg
// Brief  : Shared defines for the IFU fetch response path: XLEN, RISC-V
//          opcode constants, predictor counter reset value, predecode helpers.
// Rev    : 1.0  initial release
// ============================================================================

`ifndef XLEN
`define XLEN 32
`endif

package lieat_ifu_fetch_rspq_pkg;

   localparam int XLEN = `XLEN;

   // Major opcodes (inst[6:0])
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

   // funct3 selecting FENCE.I inside MISC-MEM
   localparam logic [2:0] F3_FENCEI    = 3'b001;

   // Predictor counters come out of reset weakly not-taken
   localparam logic [1:0] BHT_CTR_RST  = 2'b01;

   typedef struct packed {
      logic jal;
      logic jalr;
      logic bxx;
      logic fencei;
   } predec_t;

   // Classify an instruction from its opcode and funct3 fields
   function automatic predec_t predecode(input logic [6:0] opcode, input logic [2:0] funct3);
      predec_t pd;
      pd.jal    = (opcode == OPC_JAL);
      pd.jalr   = (opcode == OPC_JALR);
      pd.bxx    = (opcode == OPC_BRANCH);
      pd.fencei = (opcode == OPC_MISC_MEM) && (funct3 == F3_FENCEI);
      return pd;
   endfunction

   // 2-bit saturating counter step
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != 2'b11) nxt = ctr + 2'b01;
      end else begin
         if (ctr != 2'b00) nxt = ctr - 2'b01;
      end
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lieat_ifu_fetch_rspq_bht.sv
`default_nettype none
// ============================================================================
// Module : lieat_ifu_bht
// Brief  : Branch history table of 2-bit saturating counters. Asynchronous
//          read port returns the current (pre-update) counter; one update
//          port written at the clock edge.
// Rev    : 1.0  initial release
// ============================================================================
module lieat_ifu_bht
   import lieat_ifu_fetch_rspq_pkg::*;
#(
   parameter int ENTRIES = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [$clog2(ENTRIES)-1:0] rd_index_i,
   output logic [1:0]                 rd_data_o,
   input  logic                       upd_en_i,
   input  logic [$clog2(ENTRIES)-1:0] upd_index_i,
   input  logic                       upd_result_i
);

   localparam int IW = $clog2(ENTRIES);

   logic [1:0] ctr_q [ENTRIES];

   // Read returns the registered value, so a same-cycle update is not seen
   assign rd_data_o = ctr_q[rd_index_i];

   for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
      // Each counter resets weakly not-taken and steps on a matching update
      always_ff @(posedge clock) begin
         if (reset) begin
            ctr_q[g] <= BHT_CTR_RST;
         end else if (upd_en_i && (upd_index_i == IW'(g))) begin
            ctr_q[g] <= ctr_next(ctr_q[g], upd_result_i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lieat_ifu_fetch_rspq.sv
`default_nettype none
// ============================================================================
// Module : lieat_ifu_fetch_rspq
// Brief  : Fetch response queue. Predecodes each response at push time,
//          looks up the BHT for conditional branches, and stores the
//          prediction alongside PC/instruction. No bypass: a pushed entry
//          becomes visible at the head on the following cycle.
// Rev    : 1.0  initial release
// ============================================================================
module lieat_ifu_fetch_rspq
   import lieat_ifu_fetch_rspq_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int BHT_ENTRIES = 32
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           rsp_i_valid,
   output logic                           rsp_i_ready,
   input  logic [XLEN-1:0]                rsp_i_pc,
   input  logic [XLEN-1:0]                rsp_i_inst,
   output logic                           rsp_o_valid,
   input  logic                           rsp_o_ready,
   output logic [XLEN-1:0]                rsp_o_pc,
   output logic [XLEN-1:0]                rsp_o_inst,
   output logic                           rsp_o_prdt_taken,
   output logic [$clog2(BHT_ENTRIES)-1:0] rsp_o_prdt_index,
   output logic                           rsp_o_fencei,
   output logic [$clog2(DEPTH):0]         rsp_o_count,
   input  logic                           bxx_prdt_en,
   input  logic [$clog2(BHT_ENTRIES)-1:0] bxx_prdt_index,
   input  logic                           bxx_prdt_result
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(BHT_ENTRIES);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Payload storage (not reset; validity is carried by the count)
   logic [XLEN-1:0] pc_q     [DEPTH];
   logic [XLEN-1:0] inst_q   [DEPTH];
   logic            taken_q  [DEPTH];
   logic [IW-1:0]   index_q  [DEPTH];
   logic            fencei_q [DEPTH];

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   predec_t       pd;
   logic [IW-1:0] in_index;
   logic [1:0]    in_ctr;
   logic          in_taken;
   logic          push;
   logic          pop;

   assign rsp_i_ready = (count_q != FULL_CNT);
   assign rsp_o_valid = (count_q != '0);
   assign rsp_o_count = count_q;

   assign push = rsp_i_valid & rsp_i_ready & ~flush;
   assign pop  = rsp_o_valid & rsp_o_ready & ~flush;

   // Predecode and prediction for the incoming response
   assign pd       = predecode(rsp_i_inst[6:0], rsp_i_inst[14:12]);
   assign in_index = rsp_i_pc[IW+1:2];
   assign in_taken = pd.jal | pd.jalr | (pd.bxx & in_ctr[1]);

   lieat_ifu_bht #(
      .ENTRIES (BHT_ENTRIES)
   ) u_bht (
      .clock        (clock),
      .reset        (reset),
      .rd_index_i   (in_index),
      .rd_data_o    (in_ctr),
      .upd_en_i     (bxx_prdt_en),
      .upd_index_i  (bxx_prdt_index),
      .upd_result_i (bxx_prdt_result)
   );

   // Next-state pointers and occupancy; flush wins over push/pop
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Queue control registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Capture payload and predecoded prediction into the write slot
   always_ff @(posedge clock) begin
      if (push) begin
         pc_q[wptr_q]     <= rsp_i_pc;
         inst_q[wptr_q]   <= rsp_i_inst;
         taken_q[wptr_q]  <= in_taken;
         index_q[wptr_q]  <= in_index;
         fencei_q[wptr_q] <= pd.fencei;
      end
   end

   // Head outputs, forced to zero while the queue is empty
   always_comb begin
      rsp_o_pc         = '0;
      rsp_o_inst       = '0;
      rsp_o_prdt_taken = 1'b0;
      rsp_o_prdt_index = '0;
      rsp_o_fencei     = 1'b0;
      if (rsp_o_valid) begin
         rsp_o_pc         = pc_q[rptr_q];
         rsp_o_inst       = inst_q[rptr_q];
         rsp_o_prdt_taken = taken_q[rptr_q];
         rsp_o_prdt_index = index_q[rptr_q];
         rsp_o_fencei     = fencei_q[rptr_q];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lieat_ifu_fetch_rspq.sv
`default_nettype none
// ============================================================================
// Module : tb_lieat_ifu_fetch_rspq
// Brief  : Directed + random scoreboard bench for the fetch response queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lieat_ifu_fetch_rspq;
   import lieat_ifu_fetch_rspq_pkg::*;

   localparam int DEPTH = 4;
   localparam int BHTN  = 32;
   localparam int IW    = 5;
   localparam logic [31:0] BEQ = 32'h0000_0063;

   logic          clock = 1'b0;
   logic          reset, flush;
   logic          rsp_i_valid, rsp_i_ready;
   logic [31:0]   rsp_i_pc, rsp_i_inst;
   logic          rsp_o_valid, rsp_o_ready;
   logic [31:0]   rsp_o_pc, rsp_o_inst;
   logic          rsp_o_prdt_taken, rsp_o_fencei;
   logic [IW-1:0] rsp_o_prdt_index;
   logic [2:0]    rsp_o_count;
   logic          bxx_prdt_en, bxx_prdt_result;
   logic [IW-1:0] bxx_prdt_index;

   always #5 clock = ~clock;

   lieat_ifu_fetch_rspq #(.DEPTH(DEPTH), .BHT_ENTRIES(BHTN)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .rsp_i_valid(rsp_i_valid), .rsp_i_ready(rsp_i_ready),
      .rsp_i_pc(rsp_i_pc), .rsp_i_inst(rsp_i_inst),
      .rsp_o_valid(rsp_o_valid), .rsp_o_ready(rsp_o_ready),
      .rsp_o_pc(rsp_o_pc), .rsp_o_inst(rsp_o_inst),
      .rsp_o_prdt_taken(rsp_o_prdt_taken), .rsp_o_prdt_index(rsp_o_prdt_index),
      .rsp_o_fencei(rsp_o_fencei), .rsp_o_count(rsp_o_count),
      .bxx_prdt_en(bxx_prdt_en), .bxx_prdt_index(bxx_prdt_index),
      .bxx_prdt_result(bxx_prdt_result)
   );

   typedef struct packed {
      logic [31:0]   pc;
      logic [31:0]   inst;
      logic          tk;
      logic [IW-1:0] idx;
      logic          fi;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] mbht [BHTN];
   bit         mknown = 0;
   int         n_assert = 0;
   int         n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t expect_entry(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      logic [6:0] opc;
      opc    = inst[6:0];
      e.pc   = pc;
      e.inst = inst;
      e.idx  = pc[IW+1:2];
      e.fi   = (opc == 7'h0F) && (inst[14:12] == 3'b001);
      e.tk   = (opc == 7'h6F) || (opc == 7'h67) || ((opc == 7'h63) && mbht[e.idx][1]);
      return e;
   endfunction

   task automatic check_outputs(input string tag);
      exp_t e;
      chk({tag, ".valid"}, 64'(rsp_o_valid), 64'(sb.size() != 0));
      chk({tag, ".ready"}, 64'(rsp_i_ready), 64'(sb.size() != DEPTH));
      chk({tag, ".count"}, 64'(rsp_o_count), 64'(sb.size()));
      e = '0;
      if (sb.size() != 0) e = sb[0];
      chk({tag, ".pc"},    64'(rsp_o_pc),         64'(e.pc));
      chk({tag, ".inst"},  64'(rsp_o_inst),       64'(e.inst));
      chk({tag, ".taken"}, 64'(rsp_o_prdt_taken), 64'(e.tk));
      chk({tag, ".index"}, 64'(rsp_o_prdt_index), 64'(e.idx));
      chk({tag, ".fencei"},64'(rsp_o_fencei),     64'(e.fi));
   endtask

   // One clock: drive, check head at negedge, advance model after the edge
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic ue, input logic [IW-1:0] ui,
                        input logic ur, input logic fl, input logic rs, input string tag);
      bit   do_push, do_pop;
      exp_t e;
      rsp_i_valid = v;  rsp_i_pc = pc;  rsp_i_inst = inst;  rsp_o_ready = rdy;
      bxx_prdt_en = ue; bxx_prdt_index = ui; bxx_prdt_result = ur;
      flush = fl;       reset = rs;
      @(negedge clock);
      if (mknown) check_outputs(tag);
      do_push = v && !fl && (sb.size() != DEPTH);
      do_pop  = rdy && !fl && (sb.size() != 0);
      e = expect_entry(pc, inst);
      @(posedge clock);
      #1;
      if (rs) begin
         sb.delete();
         foreach (mbht[i]) mbht[i] = 2'b01;
         mknown = 1;
      end else begin
         if (fl) sb.delete();
         else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(e);
         end
         if (ue) begin
            if (ur && mbht[ui] != 2'b11) mbht[ui] = mbht[ui] + 2'b01;
            else if (!ur && mbht[ui] != 2'b00) mbht[ui] = mbht[ui] - 2'b01;
         end
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic rdy, input string tag);
      cycle(1'b1, pc, inst, rdy, 1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   task automatic idle(input logic rdy, input string tag);
      cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   task automatic upd(input logic [IW-1:0] idx, input logic res, input string tag);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, idx, res, 1'b0, 1'b0, tag);
   endtask

   logic [31:0] insts [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      insts[0] = 32'h0000_0063; insts[1] = 32'h0000_006F; insts[2] = 32'h0000_8067;
      insts[3] = 32'h0000_100F; insts[4] = 32'h0000_000F; insts[5] = 32'h0010_0093;

      // Reset
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "rst0");
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "rst1");
      idle(1'b0, "post_reset");

      // BEQ after reset: not taken, index 4
      push(32'h8000_0010, BEQ, 1'b0, "beq0");
      chk("r25_valid", 64'(rsp_o_valid), 64'd1);
      chk("r25_index", 64'(rsp_o_prdt_index), 64'd4);
      chk("r25_taken", 64'(rsp_o_prdt_taken), 64'd0);
      idle(1'b1, "pop_beq0");

      // Train up, then down past zero
      for (int i = 0; i < 3; i++) upd(5'd4, 1'b1, "up");
      push(32'h8000_0010, BEQ, 1'b0, "beq1");
      chk("r26_taken_hi", 64'(rsp_o_prdt_taken), 64'd1);
      idle(1'b1, "pop_beq1");
      for (int i = 0; i < 4; i++) upd(5'd4, 1'b0, "down");
      push(32'h8000_0010, BEQ, 1'b1, "beq2");
      chk("r26_taken_lo", 64'(rsp_o_prdt_taken), 64'd0);
      cycle(1'b1, 32'h8000_0010, BEQ, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, "beq3_up");
      chk("r26_no_underflow", 64'(rsp_o_prdt_taken), 64'd0);
      upd(5'd4, 1'b1, "up2");
      idle(1'b1, "pop_beq3");
      push(32'h8000_0010, BEQ, 1'b0, "beq4");
      chk("r26_taken_2", 64'(rsp_o_prdt_taken), 64'd1);
      // Same-cycle update and lookup: pre-update counter (2) used
      cycle(1'b1, 32'h8000_0010, BEQ, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, "bypass_upd");
      chk("r16_pre_update", 64'(rsp_o_prdt_taken), 64'd1);
      push(32'h8000_0010, BEQ, 1'b0, "beq5");
      idle(1'b1, "drain_a");
      idle(1'b1, "drain_b");

      // Fill to full with consumer stalled, then pop+push when full
      for (int i = 0; i < 5; i++)
         push(32'h0000_0100 + 32'(i * 4), insts[i], 1'b0, "fill");
      chk("r27_count", 64'(rsp_o_count), 64'd4);
      chk("r27_ready", 64'(rsp_i_ready), 64'd0);
      push(32'h0000_0200, insts[5], 1'b1, "full_pp");
      chk("r27_only_pop", 64'(rsp_o_count), 64'd3);
      for (int i = 0; i < 4; i++) idle(1'b1, "drain_full");

      // Flush with a push request pending; BHT update in the same cycle survives
      for (int i = 0; i < 3; i++) push(32'h0000_0300 + 32'(i * 4), insts[i], 1'b0, "pre_flush");
      cycle(1'b1, 32'h0000_0400, BEQ, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, "flush");
      chk("r28_count", 64'(rsp_o_count), 64'd0);
      chk("r28_valid", 64'(rsp_o_valid), 64'd0);
      chk("r28_pc", 64'(rsp_o_pc), 64'd0);
      chk("r28_inst", 64'(rsp_o_inst), 64'd0);
      push(32'h8000_0010, BEQ, 1'b0, "post_flush_beq");
      idle(1'b1, "pop_pf");

      // JAL / FENCE.I predecode
      push(32'h0000_0500, 32'h0000_006F, 1'b0, "jal");
      chk("r29_jal_taken", 64'(rsp_o_prdt_taken), 64'd1);
      idle(1'b1, "pop_jal");
      push(32'h0000_0504, 32'h0000_100F, 1'b0, "fencei");
      chk("r29_fencei", 64'(rsp_o_fencei), 64'd1);
      chk("r29_fencei_tk", 64'(rsp_o_prdt_taken), 64'd0);
      idle(1'b1, "pop_fi");

      // Streaming push/pop across pointer wrap
      push(32'h0000_1000, insts[5], 1'b0, "prime");
      for (int i = 1; i <= 10; i++) begin
         push(32'h0000_1000 + 32'(i * 4), insts[i % 6], 1'b1, "stream");
         chk("r30_count", 64'(rsp_o_count), 64'd1);
      end
      idle(1'b1, "drain_stream");

      // Reset mid-operation discards entries and restores counters
      push(32'h8000_0014, BEQ, 1'b0, "pre_rst_a");
      upd(5'd5, 1'b1, "pre_rst_up");
      cycle(1'b1, 32'h8000_0018, BEQ, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "mid_reset");
      chk("r20_count", 64'(rsp_o_count), 64'd0);
      push(32'h8000_0014, BEQ, 1'b0, "post_rst_beq");
      chk("r20_bht", 64'(rsp_o_prdt_taken), 64'd0);
      idle(1'b1, "pop_pr");

      // Random traffic
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00} + 32'h8000_0000,
               insts[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), IW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 15) == 0), 1'b0, "rand");
      for (int i = 0; i < 5; i++) idle(1'b1, "final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
